data_memory: RTL and testbench
==============================

# data_memory

Byte-addressable data memory with an integrated load/store alignment unit for the single-cycle RISC-V core. It sits between the ALU (address) and the writeback select mux, and produces the load value that feeds the mux's memory-data input. Stores commit on the rising clock edge, and loads are combinational within the same cycle. Misaligned or illegal accesses are suppressed, and the first one is recorded in sticky fault registers for debug.

## Interface
- `DEPTH_WORDS`, 256, number of 32-bit words; must be a power of two.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `mem_read` in 1: load enable for this cycle.
- `mem_write` in 1: store enable, committed at the next rising edge.
- `funct3` in 3: access type. 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `addr` in 32: byte address from the ALU.
- `write_data` in 32: store data from rs2; low byte or half is used for B/H.
- `read_data` out 32: extended load value for the writeback mux.
- `misaligned` out 1: combinational flag; current access is misaligned or illegal.
- `fault` out 1: sticky flag; at least one bad access has occurred since reset.
- `fault_addr` out 32: `addr` of the first bad access.

## Operation
- Word index is `addr[log2(DEPTH_WORDS)+1:2]`.
  - Upper address bits are ignored, so addresses wrap modulo `4*DEPTH_WORDS`.
  - Byte lane is `addr[1:0]`.
- A bad access is any cycle with (`mem_read` | `mem_write`) and one of:
  - H/HU with `addr[0]`=1;
  - W with `addr[1:0]`≠0;
  - `funct3` ∈ {011, 110, 111}; 100 and 101 are also bad when used with `mem_write`.
- On a bad access:
  - `misaligned`=1 in the same cycle.
  - No store is performed.
  - `read_data`=0.
- Stores (good access, `mem_write`=1) update only the addressed lanes at the rising edge:
  - SB writes 1 lane.
  - SH writes lanes {1:0} or {3:2}.
  - SW writes all 4 lanes.
- Loads (good access, `mem_read`=1):
  - The byte or half is selected by lane and shifted to bit 0.
  - B and H sign-extend; BU and HU zero-extend; W passes through unchanged.
- When `mem_read`=0, `read_data`=0.
- When `mem_read` and `mem_write` are both 1, `read_data` reflects the contents before the edge. The store is visible from the next cycle.
- Fault capture:
  - On the first bad access after reset, at the rising edge, `fault` is set to 1 and `fault_addr` is loaded with `addr`.
  - Later bad accesses do not overwrite either register.
  - Only reset clears them.

## Timing
- Load latency is 0 cycles; `read_data` is combinational from `addr`, `funct3`, `mem_read` and the array.
- Store latency is 1 edge.
- `misaligned` is combinational. `fault` and `fault_addr` are registered and rise one edge after the bad access.
- During reset (`rst_n`=0, asynchronous):
  - every array word is 0;
  - `fault`=0 and `fault_addr`=0;
  - `read_data`=0 and `misaligned` follows its inputs.
- If reset asserts in the same cycle as a store, the store is dropped and the array is cleared.
- The first rising edge after `rst_n` rises is a normal functional edge.

## Structure
- The shared package `rv_pkg` holds the `funct3` load/store constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`). The same package is used by the decoder.
- One combinational sub-module, `load_align`, implements:
  - inputs: word, lane, `funct3`;
  - output: extended 32-bit value.
- Store lane-merge, bad-access detection, the array and the fault registers stay in `data_memory`.

## Test plan
- Reset, then LW from 0x00, 0x04 and 0x3FC: `read_data`=0 for each. `fault`=0 and `fault_addr`=0.
- SW 0xA1B2C3D4 at 0x10, then:
  - LW 0x10 → 0xA1B2C3D4;
  - LB 0x10 → 0xFFFFFFD4;
  - LBU 0x13 → 0x000000A1;
  - LH 0x12 → 0xFFFFA1B2;
  - LHU 0x10 → 0x0000C3D4.
- SW 0xA1B2C3D4 at 0x20, SB 0x5A at 0x21, SH 0x1C1C at 0x22, then LW 0x20 → 0x1C1C5AD4.
- SW at 0x22 with data 0xC15C1C1C:
  - that cycle, `misaligned`=1 and `read_data`=0;
  - the word at 0x20 is unchanged;
  - after the edge, `fault`=1 and `fault_addr`=0x22.
  - A later LH at 0x05 does not change `fault_addr`.
- Wrap and same-cycle behaviour (`DEPTH_WORDS`=256):
  - SW 0x001142B3 at 0x400, then LW 0x000 → 0x001142B3.
  - With `mem_read`=`mem_write`=1 and a new value, `read_data` shows the old value that cycle and the new value the next cycle.
- Assert `rst_n`=0 mid-cycle with `mem_write`=1: the array is cleared immediately and the store is not committed. After release, LW 0x10 → 0.

Source files
------------

// File: rtl/rv_pkg.sv
// Load/store funct3 encodings shared by the decoder and the data memory,
// plus the bad-access rule for a given encoding, byte lane and direction.
package rv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unsigned variants exist only for loads; encodings 011/110/111 are never legal.
  function automatic logic ls_bad(input logic [2:0] f3, input logic [1:0] lane,
                                  input logic wr);
    logic bad;
    case (f3)
      F3_B:    bad = 1'b0;
      F3_BU:   bad = wr;
      F3_H:    bad = lane[0];
      F3_HU:   bad = wr | lane[0];
      F3_W:    bad = |lane;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/half of a memory word, moves it to bit 0 and
// sign- or zero-extends it according to funct3.
module load_align
  import rv_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data = {24'h0, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data = {16'h0, half_sel};
      F3_W:    data = word;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/data_memory.sv
// Byte-addressable data memory with store lane-merge, combinational aligned
// loads, bad-access suppression and a sticky first-fault capture.
module data_memory
  import rv_pkg::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        misaligned,
  output logic        fault,
  output logic [31:0] fault_addr
);

  localparam int AW        = $clog2(DEPTH_WORDS);
  localparam int NUM_LANES = 4;

  logic [31:0]          mem_q [DEPTH_WORDS];
  logic [AW-1:0]        word_idx;
  logic [1:0]           lane;
  logic [31:0]          cur_word;
  logic [31:0]          mem_d;
  logic [31:0]          wbus;
  logic [NUM_LANES-1:0] be;
  logic                 bad;
  logic                 store_en;
  logic [31:0]          load_val;

  logic                 fault_q, fault_d;
  logic [31:0]          fault_addr_q, fault_addr_d;

  // Upper address bits are dropped, so addresses wrap modulo the array size.
  assign word_idx = addr[AW+1:2];
  assign lane     = addr[1:0];
  assign cur_word = mem_q[word_idx];

  assign bad      = (mem_read | mem_write) & ls_bad(funct3, lane, mem_write);
  assign store_en = mem_write & ~bad;

  always_comb begin
    be   = '0;
    wbus = write_data;
    case (funct3)
      F3_B: begin
        be   = 4'b0001 << lane;
        wbus = {4{write_data[7:0]}};
      end
      F3_H: begin
        be   = lane[1] ? 4'b1100 : 4'b0011;
        wbus = {2{write_data[15:0]}};
      end
      F3_W:    be = 4'b1111;
      default: be = '0;
    endcase
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign mem_d[l*8 +: 8] = be[l] ? wbus[l*8 +: 8] : cur_word[l*8 +: 8];
  end

  always_comb begin
    fault_d      = fault_q | bad;
    fault_addr_d = (bad & ~fault_q) ? addr : fault_addr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      if (store_en) mem_q[word_idx] <= mem_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  load_align u_load_align (
    .word   (cur_word),
    .lane   (lane),
    .funct3 (funct3),
    .data   (load_val)
  );

  // Same-cycle read+write sees the pre-edge word since the array is read combinationally.
  assign read_data  = (rst_n && mem_read && !bad) ? load_val : 32'h0;
  assign misaligned = bad;
  assign fault      = fault_q;
  assign fault_addr = fault_addr_q;

endmodule

// File: tb/tb_data_memory.sv
// Directed vector bench for data_memory: per-cycle table plus reset corner sequence.
module tb_data_memory;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, write_data;
  logic [31:0] read_data;
  logic        misaligned, fault;
  logic [31:0] fault_addr;

  int n_cmp = 0;
  int n_bad = 0;

  data_memory #(.DEPTH_WORDS(256)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .addr       (addr),
    .write_data (write_data),
    .read_data  (read_data),
    .misaligned (misaligned),
    .fault      (fault),
    .fault_addr (fault_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        re;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        mis;
    logic        flt;
    logic [31:0] faddr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic we, input logic re, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rd, input logic mis,
                              input logic flt, input logic [31:0] faddr);
    vec_t v;
    v.we = we; v.re = re; v.f3 = f3; v.a = a; v.wd = wd;
    v.rd = rd; v.mis = mis; v.flt = flt; v.faddr = faddr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic re, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    mem_write = we; mem_read = re; funct3 = f3; addr = a; write_data = wd;
  endtask

  initial begin
    // {we, re, f3, addr, wdata, exp read_data, exp misaligned, exp fault, exp fault_addr}
    vecs.push_back(mk(0, 1, F3_W,  32'h000, 32'h0,        32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(0, 1, F3_W,  32'h004, 32'h0,        32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(0, 1, F3_W,  32'h3FC, 32'h0,        32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(1, 0, F3_W,  32'h010, 32'hA1B2C3D4, 32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(0, 1, F3_W,  32'h010, 32'h0,        32'hA1B2C3D4, 0, 0, 32'h0));
    vecs.push_back(mk(0, 1, F3_B,  32'h010, 32'h0,        32'hFFFFFFD4, 0, 0, 32'h0));
    vecs.push_back(mk(0, 1, F3_BU, 32'h013, 32'h0,        32'h000000A1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 1, F3_H,  32'h012, 32'h0,        32'hFFFFA1B2, 0, 0, 32'h0));
    vecs.push_back(mk(0, 1, F3_HU, 32'h010, 32'h0,        32'h0000C3D4, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, F3_W,  32'h020, 32'hA1B2C3D4, 32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(1, 0, F3_B,  32'h021, 32'h0000005A, 32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(1, 0, F3_H,  32'h022, 32'h00001C1C, 32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(0, 1, F3_W,  32'h020, 32'h0,        32'h1C1C5AD4, 0, 0, 32'h0));
    // misaligned SW with a concurrent read: suppressed, first fault captured
    vecs.push_back(mk(1, 1, F3_W,  32'h022, 32'hC15C1C1C, 32'h0,        1, 0, 32'h0));
    vecs.push_back(mk(0, 1, F3_W,  32'h020, 32'h0,        32'h1C1C5AD4, 0, 1, 32'h22));
    vecs.push_back(mk(0, 1, F3_H,  32'h005, 32'h0,        32'h0,        1, 1, 32'h22));
    vecs.push_back(mk(0, 1, 3'b011,32'h000, 32'h0,        32'h0,        1, 1, 32'h22));
    vecs.push_back(mk(0, 1, F3_HU, 32'h003, 32'h0,        32'h0,        1, 1, 32'h22));
    vecs.push_back(mk(1, 0, F3_BU, 32'h030, 32'h000000FF, 32'h0,        1, 1, 32'h22));
    vecs.push_back(mk(0, 1, F3_W,  32'h030, 32'h0,        32'h0,        0, 1, 32'h22));
    vecs.push_back(mk(0, 0, 3'b111,32'h031, 32'h0,        32'h0,        0, 1, 32'h22));
    // wrap modulo 1 KiB, then same-cycle read+write
    vecs.push_back(mk(1, 0, F3_W,  32'h400, 32'h001142B3, 32'h0,        0, 1, 32'h22));
    vecs.push_back(mk(0, 1, F3_W,  32'h000, 32'h0,        32'h001142B3, 0, 1, 32'h22));
    vecs.push_back(mk(1, 0, F3_W,  32'h040, 32'h11111111, 32'h0,        0, 1, 32'h22));
    vecs.push_back(mk(1, 1, F3_W,  32'h040, 32'h22222222, 32'h11111111, 0, 1, 32'h22));
    vecs.push_back(mk(0, 1, F3_W,  32'h040, 32'h0,        32'h22222222, 0, 1, 32'h22));
    vecs.push_back(mk(0, 1, F3_B,  32'h043, 32'h0,        32'h00000022, 0, 1, 32'h22));

    rst_n = 1'b0;
    drive(0, 1, F3_W, 32'h0, 32'h0);
    #2;
    chk("rst_read_data", read_data, 32'h0);
    chk("rst_fault", {31'h0, fault}, 32'h0);
    chk("rst_fault_addr", fault_addr, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].we, vecs[i].re, vecs[i].f3, vecs[i].a, vecs[i].wd);
      @(negedge clk);
      chk($sformatf("v%0d_read_data", i), read_data, vecs[i].rd);
      chk($sformatf("v%0d_misaligned", i), {31'h0, misaligned}, {31'h0, vecs[i].mis});
      chk($sformatf("v%0d_fault", i), {31'h0, fault}, {31'h0, vecs[i].flt});
      chk($sformatf("v%0d_fault_addr", i), fault_addr, vecs[i].faddr);
      @(posedge clk);
      #1;
    end

    // Asynchronous reset mid-cycle while a store is pending.
    drive(1, 1, F3_W, 32'h010, 32'hDEADBEEF);
    #1;
    chk("pre_rst_read_old", read_data, 32'hA1B2C3D4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_read_data", read_data, 32'h0);
    chk("async_rst_fault", {31'h0, fault}, 32'h0);
    chk("async_rst_fault_addr", fault_addr, 32'h0);
    @(posedge clk);
    #1;
    drive(0, 1, F3_W, 32'h010, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_lw_10", read_data, 32'h0);
    addr = 32'h000;
    #1;
    chk("post_rst_lw_00", read_data, 32'h0);
    addr = 32'h040;
    #1;
    chk("post_rst_lw_40", read_data, 32'h0);
    @(posedge clk);
    #1;
    // First edge after release is functional.
    drive(1, 0, F3_W, 32'h010, 32'h5A5A0F0F);
    @(posedge clk);
    #1;
    drive(0, 1, F3_W, 32'h010, 32'h0);
    #1;
    chk("post_rst_store", read_data, 32'h5A5A0F0F);
    chk("post_rst_fault", {31'h0, fault}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
